// File: rtl/cpu_output_fifo_pkg.sv
// Shared constants and helpers for the CPU output FIFO.
package cpu_output_fifo_pkg;

    localparam int unsigned OUT_DATA_WIDTH = 16;
    localparam int unsigned OUT_FIFO_DEPTH = 8;

    // Pointer width needed to address a FIFO of the given depth.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/cpu_output_fifo_mem_2p.sv
// Simple dual-port storage array: synchronous write, combinational read.
module fifo_mem_2p
    import cpu_output_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = OUT_DATA_WIDTH,
    parameter int unsigned DEPTH      = OUT_FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rd_data_c
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage carries no reset; occupancy tracking in the parent decides validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rd_data_c = mem_q[raddr];

endmodule

// File: rtl/cpu_output_fifo.sv
// Buffered CPU output port: circular FIFO with CPU stall, sticky overflow and
// halt-drain indication toward a valid/ready consumer.
module cpu_output_fifo
    import cpu_output_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = OUT_DATA_WIDTH,
    parameter int unsigned DEPTH      = OUT_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      stall,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    input  logic                      clr_overflow,
    input  logic                      hlt_in,
    output logic                      drained
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          stall_q, stall_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          halted_q, halted_d;
    logic          drained_q, drained_d;
    logic          wr_acc_c;
    logic          rd_acc_c;

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PW)
    ) u_mem (
        .clk       (clk),
        .we        (wr_acc_c),
        .waddr     (wp_q),
        .wdata     (wr_data),
        .raddr     (rp_q),
        .rd_data_c (rd_data)
    );

    // Accept decisions use the registered flags, so a full FIFO rejects a
    // write even when a read frees a slot in the same cycle.
    always_comb begin
        wr_acc_c   = wr_en & ~stall_q & ~halted_q;
        rd_acc_c   = rd_valid_q & rd_ready;
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        if (wr_acc_c) begin
            wp_d = wp_q + PW'(1);
        end
        if (rd_acc_c) begin
            rp_d = rp_q + PW'(1);
        end
        if (wr_acc_c && !rd_acc_c) begin
            count_d = count_q + CW'(1);
        end else if (!wr_acc_c && rd_acc_c) begin
            count_d = count_q - CW'(1);
        end
        stall_d    = (count_d == CW'(DEPTH));
        rd_valid_d = (count_d != CW'(0));
        overflow_d = (wr_en & stall_q & ~halted_q) | (overflow_q & ~clr_overflow);
        halted_d   = halted_q | hlt_in;
        drained_d  = halted_q & (count_q == CW'(0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
            drained_q  <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            halted_q   <= halted_d;
            drained_q  <= drained_d;
        end
    end

    assign stall    = stall_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign drained  = drained_q;

endmodule
